// File: rtl/neureka_package.sv
// -----------------------------------------------------------------------------
// neureka_package
// Shared constants and types for the TCDM port splitter.
//   NEUREKA_SPLIT_N_PORTS_DEFAULT : default number of narrow TCDM ports
//   NEUREKA_SPLIT_OUTST_DEFAULT   : default max outstanding wide reads
//   split_flags_t                 : {busy, credit, granted} status snapshot
//   split_port_offset()           : byte offset of narrow port k
// -----------------------------------------------------------------------------
package neureka_package;

    localparam int unsigned NEUREKA_SPLIT_N_PORTS_DEFAULT = 4;
    localparam int unsigned NEUREKA_SPLIT_OUTST_DEFAULT   = 2;
    localparam int unsigned NEUREKA_SPLIT_CREDIT_W        = $clog2(NEUREKA_SPLIT_OUTST_DEFAULT + 1);

    typedef struct packed {
        logic                                     busy;
        logic [NEUREKA_SPLIT_CREDIT_W-1:0]        credit;
        logic [NEUREKA_SPLIT_N_PORTS_DEFAULT-1:0] granted;
    } split_flags_t;

    function automatic int unsigned split_port_offset(input int unsigned k,
                                                      input int unsigned dw_port);
        return k * (dw_port / 8);
    endfunction

endpackage

// File: rtl/neureka_split_resp_fifo.sv
// -----------------------------------------------------------------------------
// neureka_split_resp_fifo
// Per-port read response FIFO. Push and pop in the same cycle are both
// honoured. Head data is visible on data_o whenever empty_o is low.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : sync flush (pointers and fill level)
//   push_i/data_i : write one entry
//   pop_i         : discard the head entry
//   data_o        : head entry
//   empty_o/full_o: fill status
// -----------------------------------------------------------------------------
module neureka_split_resp_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i) cnt_d = cnt_q + CW'(1);
        else if (!push_i && pop_i) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/neureka_tcdm_port_splitter.sv
// -----------------------------------------------------------------------------
// neureka_tcdm_port_splitter
// Splits one wide streamer TCDM transaction into N_PORTS word-aligned narrow
// transactions and reassembles the narrow read responses into one wide
// response. Reads are limited to OUTST outstanding by a credit counter, which
// also bounds the per-port response FIFOs.
//
// Ports:
//   clk_i, rst_ni, clear_i        : clock, async reset, idle-only soft clear
//   w_req/gnt/wen/add/be/data     : wide request side (wen=1 means read)
//   w_r_valid/ready/data          : wide read response (valid/ready)
//   p_req/gnt/wen/add/be/data     : narrow per-port request side
//   p_r_valid/data                : narrow per-port responses, no backpressure
//   busy_o                        : outstanding reads or partial grants
//   perf_stall_o                  : stall cycle counter (NEUREKA_SPLITTER_PERF_EN)
//
// Build option: define NEUREKA_SPLITTER_PERF_EN to add perf_stall_o.
// -----------------------------------------------------------------------------
module neureka_tcdm_port_splitter
    import neureka_package::*;
#(
    parameter int unsigned N_PORTS = NEUREKA_SPLIT_N_PORTS_DEFAULT,
    parameter int unsigned DW_PORT = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned OUTST   = NEUREKA_SPLIT_OUTST_DEFAULT
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           w_req_i,
    output logic                           w_gnt_o,
    input  logic                           w_wen_i,
    input  logic [AW-1:0]                  w_add_i,
    input  logic [N_PORTS*DW_PORT/8-1:0]   w_be_i,
    input  logic [N_PORTS*DW_PORT-1:0]     w_data_i,
    output logic                           w_r_valid_o,
    input  logic                           w_r_ready_i,
    output logic [N_PORTS*DW_PORT-1:0]     w_r_data_o,
    output logic [N_PORTS-1:0]             p_req_o,
    input  logic [N_PORTS-1:0]             p_gnt_i,
    output logic [N_PORTS-1:0]             p_wen_o,
    output logic [N_PORTS*AW-1:0]          p_add_o,
    output logic [N_PORTS*DW_PORT/8-1:0]   p_be_o,
    output logic [N_PORTS*DW_PORT-1:0]     p_data_o,
    input  logic [N_PORTS-1:0]             p_r_valid_i,
    input  logic [N_PORTS*DW_PORT-1:0]     p_r_data_i,
    output logic                           busy_o
`ifdef NEUREKA_SPLITTER_PERF_EN
   ,output logic [31:0]                    perf_stall_o
`endif
);

    localparam int unsigned CW = $clog2(OUTST + 1);

    logic [N_PORTS-1:0] granted_q, granted_d;
    logic [CW-1:0]      credit_q, credit_d;
    logic               issue, rd_inc, resp_hs, clear_eff;
    logic [N_PORTS-1:0] fifo_empty, fifo_full, fifo_push;

    // Writes never consume credit; reads stall once OUTST are in flight.
    assign issue     = w_req_i && (!w_wen_i || (credit_q < CW'(OUTST)));
    assign p_req_o   = issue ? ~granted_q : '0;
    assign w_gnt_o   = issue && (&(granted_q | p_gnt_i));
    assign rd_inc    = w_gnt_o && w_wen_i;
    assign resp_hs   = w_r_valid_o && w_r_ready_i;
    assign busy_o    = (credit_q != '0) || (|granted_q);
    assign clear_eff = clear_i && !busy_o;

    assign p_wen_o  = {N_PORTS{w_wen_i}};
    assign p_be_o   = w_be_i;
    assign p_data_o = w_data_i;

    always_comb begin
        granted_d = granted_q | (p_gnt_i & p_req_o);
        if (w_gnt_o) granted_d = '0;
    end

    always_comb begin
        credit_d = credit_q;
        if (rd_inc && !resp_hs) credit_d = credit_q + CW'(1);
        else if (!rd_inc && resp_hs) credit_d = credit_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            granted_q <= '0;
            credit_q  <= '0;
        end else if (clear_eff) begin
            granted_q <= '0;
            credit_q  <= '0;
        end else begin
            granted_q <= granted_d;
            credit_q  <= credit_d;
        end
    end

    for (genvar k = 0; k < N_PORTS; k++) begin : g_port
        // Address arithmetic wraps modulo 2^AW.
        assign p_add_o[k*AW +: AW] = w_add_i + AW'(split_port_offset(k, DW_PORT));

        // A full FIFO only accepts when draining in the same cycle.
        assign fifo_push[k] = p_r_valid_i[k] && (!fifo_full[k] || resp_hs);

        neureka_split_resp_fifo #(
            .DW    (DW_PORT),
            .DEPTH (OUTST)
        ) i_resp_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear_eff),
            .push_i  (fifo_push[k]),
            .data_i  (p_r_data_i[k*DW_PORT +: DW_PORT]),
            .pop_i   (resp_hs),
            .data_o  (w_r_data_o[k*DW_PORT +: DW_PORT]),
            .empty_o (fifo_empty[k]),
            .full_o  (fifo_full[k])
        );
    end

    assign w_r_valid_o = ~|fifo_empty;

`ifdef NEUREKA_SPLITTER_PERF_EN
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_stall_q <= '0;
        end else if (clear_eff) begin
            perf_stall_q <= '0;
        end else if (w_req_i && !w_gnt_o && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_neureka_tcdm_port_splitter.sv
module tb_neureka_tcdm_port_splitter;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          w_req_i;
    logic          w_gnt_o;
    logic          w_wen_i;
    logic [31:0]   w_add_i;
    logic [15:0]   w_be_i;
    logic [127:0]  w_data_i;
    logic          w_r_valid_o;
    logic          w_r_ready_i;
    logic [127:0]  w_r_data_o;
    logic [3:0]    p_req_o;
    logic [3:0]    p_gnt_i;
    logic [3:0]    p_wen_o;
    logic [127:0]  p_add_o;
    logic [15:0]   p_be_o;
    logic [127:0]  p_data_o;
    logic [3:0]    p_r_valid_i;
    logic [127:0]  p_r_data_i;
    logic          busy_o;
`ifdef NEUREKA_SPLITTER_PERF_EN
    logic [31:0]   perf_stall_o;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [127:0] exp_q [$];

    always #5 clk_i = ~clk_i;

    neureka_tcdm_port_splitter #(
        .N_PORTS (4),
        .DW_PORT (32),
        .AW      (32),
        .OUTST   (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .w_req_i     (w_req_i),
        .w_gnt_o     (w_gnt_o),
        .w_wen_i     (w_wen_i),
        .w_add_i     (w_add_i),
        .w_be_i      (w_be_i),
        .w_data_i    (w_data_i),
        .w_r_valid_o (w_r_valid_o),
        .w_r_ready_i (w_r_ready_i),
        .w_r_data_o  (w_r_data_o),
        .p_req_o     (p_req_o),
        .p_gnt_i     (p_gnt_i),
        .p_wen_o     (p_wen_o),
        .p_add_o     (p_add_o),
        .p_be_o      (p_be_o),
        .p_data_o    (p_data_o),
        .p_r_valid_i (p_r_valid_i),
        .p_r_data_i  (p_r_data_i),
        .busy_o      (busy_o)
`ifdef NEUREKA_SPLITTER_PERF_EN
       ,.perf_stall_o (perf_stall_o)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic nc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_resp(input logic [127:0] d);
        p_r_valid_i = 4'hF;
        p_r_data_i  = d;
        exp_q.push_back(d);
    endtask

    task automatic check_resp(input string tag);
        check({tag, "_valid"}, {127'd0, w_r_valid_o}, 128'd1);
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 128'd1, 128'd0);
        else check(tag, w_r_data_o, exp_q.pop_front());
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; w_req_i = 1'b0; w_wen_i = 1'b0;
        w_add_i = '0; w_be_i = '0; w_data_i = '0; w_r_ready_i = 1'b1;
        p_gnt_i = '0; p_r_valid_i = '0; p_r_data_i = '0;
        #12;
        check("rst_w_gnt",   {127'd0, w_gnt_o}, 128'd0);
        check("rst_p_req",   {124'd0, p_req_o}, 128'd0);
        check("rst_busy",    {127'd0, busy_o}, 128'd0);
        check("rst_r_valid", {127'd0, w_r_valid_o}, 128'd0);
        check("rst_r_data",  w_r_data_o, 128'd0);
        rst_ni = 1'b1;

        // Read with all grants in one cycle
        nc();
        w_req_i = 1; w_wen_i = 1; w_add_i = 32'h1000; p_gnt_i = 4'hF;
        #1;
        check("rd_w_gnt", {127'd0, w_gnt_o}, 128'd1);
        check("rd_p_req", {124'd0, p_req_o}, 128'hF);
        check("rd_p_wen", {124'd0, p_wen_o}, 128'hF);
        check("rd_p_add", p_add_o, {32'h100C, 32'h1008, 32'h1004, 32'h1000});
        nc();
        w_req_i = 0; p_gnt_i = 0;
        drive_resp({32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0});
        #1;
        check("rd_busy", {127'd0, busy_o}, 128'd1);
        check("rd_no_valid_yet", {127'd0, w_r_valid_o}, 128'd0);
        nc();
        p_r_valid_i = 0;
        #1;
        check_resp("rd_data");
        nc(); #1;
        check("rd_idle", {127'd0, busy_o}, 128'd0);
        check("rd_drained", {127'd0, w_r_valid_o}, 128'd0);

        // Staggered grants
        nc();
        w_req_i = 1; w_wen_i = 1; w_add_i = 32'h2000; p_gnt_i = 4'b0001;
        #1;
        check("stg0_p_req", {124'd0, p_req_o}, 128'hF);
        check("stg0_gnt", {127'd0, w_gnt_o}, 128'd0);
        nc();
        p_gnt_i = 4'b0100;
        #1;
        check("stg1_p_req", {124'd0, p_req_o}, 128'hE);
        check("stg1_gnt", {127'd0, w_gnt_o}, 128'd0);
        nc();
        p_gnt_i = 4'b0000;
        #1;
        check("stg2_p_req", {124'd0, p_req_o}, 128'hA);
        check("stg2_gnt", {127'd0, w_gnt_o}, 128'd0);
        nc();
        p_gnt_i = 4'b1010;
        #1;
        check("stg3_p_req", {124'd0, p_req_o}, 128'hA);
        check("stg3_gnt", {127'd0, w_gnt_o}, 128'd1);
        nc();
        w_req_i = 0; p_gnt_i = 0;
        drive_resp({32'h13, 32'h12, 32'h11, 32'h10});
        #1;
        check("stg_p_req_idle", {124'd0, p_req_o}, 128'h0);
        check("stg_busy", {127'd0, busy_o}, 128'd1);
        nc();
        p_r_valid_i = 0;
        #1;
        check_resp("stg_data");
        nc(); #1;
        check("stg_idle", {127'd0, busy_o}, 128'd0);

        // Credit limit with response backpressure
        w_r_ready_i = 0;
        nc();
        w_req_i = 1; w_wen_i = 1; w_add_i = 32'h3000; p_gnt_i = 4'hF;
        #1;
        check("cr_a_gnt", {127'd0, w_gnt_o}, 128'd1);
        nc();
        w_add_i = 32'h3100;
        #1;
        check("cr_b_gnt", {127'd0, w_gnt_o}, 128'd1);
        nc();
        w_add_i = 32'h3200;
        drive_resp({32'hA3, 32'hA2, 32'hA1, 32'hA0});
        #1;
        check("cr_c_blocked", {127'd0, w_gnt_o}, 128'd0);
        check("cr_c_p_req", {124'd0, p_req_o}, 128'h0);
        nc();
        drive_resp({32'hB3, 32'hB2, 32'hB1, 32'hB0});
        #1;
        check("cr_valid_held", {127'd0, w_r_valid_o}, 128'd1);
        check("cr_c_still_blocked", {127'd0, w_gnt_o}, 128'd0);
        nc();
        p_r_valid_i = 0; w_r_ready_i = 1;
        #1;
        check("cr_c_blocked_hs", {127'd0, w_gnt_o}, 128'd0);
        check_resp("cr_data_a");
        nc(); #1;
        check("cr_c_gnt", {127'd0, w_gnt_o}, 128'd1);
        check_resp("cr_data_b");
        nc();
        w_req_i = 0; p_gnt_i = 0;
        drive_resp({32'hC3, 32'hC2, 32'hC1, 32'hC0});
        #1;
        check("cr_busy_one", {127'd0, busy_o}, 128'd1);
        check("cr_empty", {127'd0, w_r_valid_o}, 128'd0);
        nc();
        p_r_valid_i = 0;
        #1;
        check_resp("cr_data_c");
        nc(); #1;
        check("cr_idle", {127'd0, busy_o}, 128'd0);

        // Write with sparse byte enables
        nc();
        w_req_i = 1; w_wen_i = 0; w_add_i = 32'h4000; w_be_i = 16'h00F0;
        w_data_i = {32'h44444444, 32'h33333333, 32'hAABBCCDD, 32'h11111111};
        p_gnt_i = 4'hF;
        #1;
        check("wr_p_req", {124'd0, p_req_o}, 128'hF);
        check("wr_p_wen", {124'd0, p_wen_o}, 128'h0);
        check("wr_p_be", {112'd0, p_be_o}, 128'h00F0);
        check("wr_p_data", p_data_o, {32'h44444444, 32'h33333333, 32'hAABBCCDD, 32'h11111111});
        check("wr_gnt", {127'd0, w_gnt_o}, 128'd1);
        nc();
        w_req_i = 0; p_gnt_i = 0; w_be_i = 0; w_data_i = 0;
        #1;
        check("wr_not_busy", {127'd0, busy_o}, 128'd0);
        check("wr_no_resp", {127'd0, w_r_valid_o}, 128'd0);

        // Address wrap
        nc();
        w_add_i = 32'hFFFFFFF8;
        #1;
        check("wrap_p_add", p_add_o, {32'h00000004, 32'h00000000, 32'hFFFFFFFC, 32'hFFFFFFF8});

        // Clear while busy is ignored
        nc();
        w_req_i = 1; w_wen_i = 1; w_add_i = 32'h5000; p_gnt_i = 4'b0001;
        #1;
        check("clr_gnt0", {127'd0, w_gnt_o}, 128'd0);
        nc();
        p_gnt_i = 0; clear_i = 1;
        #1;
        check("clr_busy", {127'd0, busy_o}, 128'd1);
        nc();
        clear_i = 0;
        #1;
        check("clr_kept_mask", {124'd0, p_req_o}, 128'hE);
        p_gnt_i = 4'b1110;
        #1;
        check("clr_gnt_rest", {127'd0, w_gnt_o}, 128'd1);
        nc();
        w_req_i = 0; p_gnt_i = 0;
        drive_resp({32'h53, 32'h52, 32'h51, 32'h50});
        nc();
        p_r_valid_i = 0;
        #1;
        check_resp("clr_data");
        nc(); #1;
        check("clr_idle", {127'd0, busy_o}, 128'd0);

`ifdef NEUREKA_SPLITTER_PERF_EN
        check("perf_counted", {127'd0, perf_stall_o != 32'd0}, 128'd1);
        clear_i = 1;
        nc();
        clear_i = 0;
        #1;
        check("perf_cleared", {96'd0, perf_stall_o}, 128'd0);
`endif

        check("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
